// File: rtl/align_shift_pipe.sv
// align_shift_pipe: pipelined alignment / normalisation barrel shifter.
// Right mode produces {mantissa, guard, round} plus sticky; left mode
// zero-fills and flags any set bit pushed off the MSB. Log stages run LSB
// first, GROUP of them per register stage, with a valid/ready handshake
// and a tag that travels with each operation.
module align_shift_pipe #(
  parameter int unsigned WIDTH   = 24,
  parameter int unsigned SHIFT_W = 5,
  parameter int unsigned GROUP   = 3,
  parameter int unsigned TAG_W   = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_data,
  input  logic [SHIFT_W-1:0] in_shamt,
  input  logic               in_dir,
  input  logic [TAG_W-1:0]   in_tag,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH+1:0]   out_data,
  output logic               out_sticky,
  output logic               out_ovf,
  output logic [TAG_W-1:0]   out_tag
);

  localparam int unsigned DW  = WIDTH + 2;
  localparam int unsigned LAT = (SHIFT_W + GROUP - 1) / GROUP;
  localparam logic [DW-1:0] ONES = '1;

  logic en;

  // Whole pipe advances together unless the output is held by back-pressure.
  always_comb begin
    en = !out_valid || out_ready;
  end

  assign in_ready = en;

  for (genvar g = 0; g < LAT; g++) begin : gen_chunk
    localparam int unsigned BASE = g * GROUP;
    localparam int unsigned SW_G = SHIFT_W - BASE;
    localparam int unsigned NL   = (SW_G < GROUP) ? SW_G : GROUP;

    // Operands entering this chunk: the ports for chunk 0, else the previous register.
    logic              src_valid;
    logic [DW-1:0]     src_data;
    logic [SW_G-1:0]   src_shamt;
    logic              src_dir;
    logic [TAG_W-1:0]  src_tag;
    logic              src_sticky;
    logic              src_ovf;

    if (g == 0) begin : gen_src_in
      // Extend with guard and round positions below the mantissa.
      always_comb begin
        src_valid  = in_valid;
        src_data   = {in_data, 2'b00};
        src_shamt  = in_shamt;
        src_dir    = in_dir;
        src_tag    = in_tag;
        src_sticky = 1'b0;
        src_ovf    = 1'b0;
      end
    end else begin : gen_src_reg
      // Pick up the partially shifted operand from the previous chunk.
      always_comb begin
        src_valid  = gen_chunk[g-1].valid_q;
        src_data   = gen_chunk[g-1].data_q;
        src_shamt  = gen_chunk[g-1].gen_fwd.shamt_q;
        src_dir    = gen_chunk[g-1].gen_fwd.dir_q;
        src_tag    = gen_chunk[g-1].tag_q;
        src_sticky = gen_chunk[g-1].sticky_q;
        src_ovf    = gen_chunk[g-1].ovf_q;
      end
    end

    for (genvar j = 0; j < NL; j++) begin : gen_log
      localparam int unsigned SH = 1 << (BASE + j);

      logic [DW-1:0] i_data;
      logic [DW-1:0] o_data;
      logic          i_sticky;
      logic          o_sticky;
      logic          i_ovf;
      logic          o_ovf;

      if (j == 0) begin : gen_first
        assign i_data   = src_data;
        assign i_sticky = src_sticky;
        assign i_ovf    = src_ovf;
      end else begin : gen_next
        assign i_data   = gen_log[j-1].o_data;
        assign i_sticky = gen_log[j-1].o_sticky;
        assign i_ovf    = gen_log[j-1].o_ovf;
      end

      // Shift by 2^(BASE+j) when that amount bit is set; OR lost bits into sticky/ovf.
      always_comb begin
        o_data   = i_data;
        o_sticky = i_sticky;
        o_ovf    = i_ovf;
        if (src_shamt[j]) begin
          if (src_dir) begin
            o_data = i_data << SH;
            o_ovf  = i_ovf | (|(i_data & ~(ONES >> SH)));
          end else begin
            o_data   = i_data >> SH;
            o_sticky = i_sticky | (|(i_data & ~(ONES << SH)));
          end
        end
      end
    end

    logic             valid_d;
    logic             valid_q;
    logic [DW-1:0]    data_d;
    logic [DW-1:0]    data_q;
    logic [TAG_W-1:0] tag_d;
    logic [TAG_W-1:0] tag_q;
    logic             sticky_d;
    logic             sticky_q;
    logic             ovf_d;
    logic             ovf_q;

    // Load the chunk result when the pipe advances, otherwise hold.
    always_comb begin
      valid_d  = valid_q;
      data_d   = data_q;
      tag_d    = tag_q;
      sticky_d = sticky_q;
      ovf_d    = ovf_q;
      if (en) begin
        valid_d  = src_valid;
        data_d   = gen_log[NL-1].o_data;
        tag_d    = src_tag;
        sticky_d = gen_log[NL-1].o_sticky;
        ovf_d    = gen_log[NL-1].o_ovf;
      end
    end

    // Chunk register; reset clears valid and the payload so outputs read zero.
    always_ff @(posedge clk) begin
      if (rst) begin
        valid_q  <= 1'b0;
        data_q   <= '0;
        tag_q    <= '0;
        sticky_q <= 1'b0;
        ovf_q    <= 1'b0;
      end else begin
        valid_q  <= valid_d;
        data_q   <= data_d;
        tag_q    <= tag_d;
        sticky_q <= sticky_d;
        ovf_q    <= ovf_d;
      end
    end

    if (g < LAT - 1) begin : gen_fwd
      localparam int unsigned RW = SW_G - NL;

      logic [RW-1:0] shamt_d;
      logic [RW-1:0] shamt_q;
      logic          dir_d;
      logic          dir_q;

      // Only the unresolved amount bits and the direction travel onward.
      always_comb begin
        shamt_d = shamt_q;
        dir_d   = dir_q;
        if (en) begin
          shamt_d = src_shamt[SW_G-1:NL];
          dir_d   = src_dir;
        end
      end

      // Control sideband register for the next chunk.
      always_ff @(posedge clk) begin
        if (rst) begin
          shamt_q <= '0;
          dir_q   <= 1'b0;
        end else begin
          shamt_q <= shamt_d;
          dir_q   <= dir_d;
        end
      end
    end
  end

  assign out_valid  = gen_chunk[LAT-1].valid_q;
  assign out_data   = gen_chunk[LAT-1].data_q;
  assign out_sticky = gen_chunk[LAT-1].sticky_q;
  assign out_ovf    = gen_chunk[LAT-1].ovf_q;
  assign out_tag    = gen_chunk[LAT-1].tag_q;

endmodule
